// File: rtl/adc_line_in_sequencer.sv
// adc_line_in_sequencer: paced ADC command source and response-to-audio sample converter.
// Optional response timeout in WAIT_RSP is built when ADC_SEQ_TIMEOUT_EN is defined.
module adc_line_in_sequencer #(
   parameter int SAMPLE_DIV = 208,
   parameter int CHANNEL    = 1,
   parameter int TIMEOUT    = 64
) (
   input  logic        clk_clk,
   input  logic        reset_reset_n,
   input  logic        enable,
   input  logic        clear,
   output logic        cmd_valid,
   output logic [4:0]  cmd_channel,
   output logic        cmd_sop,
   output logic        cmd_eop,
   input  logic        cmd_ready,
   input  logic        rsp_valid,
   input  logic [4:0]  rsp_channel,
   input  logic [11:0] rsp_data,
   input  logic        rsp_sop,
   input  logic        rsp_eop,
   output logic        sample_valid,
   output logic [15:0] sample_data,
   output logic        overrun,
   output logic        error
);
   localparam int CW = $clog2(SAMPLE_DIV);
   typedef enum logic [1:0] {IDLE, CMD, WAIT_RSP} state_t;
   state_t state, state_n;
   logic [CW-1:0] count;
   logic tick, rsp_match, timed_out, unused;
   logic cmd_valid_n, sample_valid_n, overrun_n, error_n;
   logic [15:0] sample_data_n;
   assign cmd_channel = 5'(CHANNEL);
   assign cmd_sop = cmd_valid;
   assign cmd_eop = cmd_valid;
   assign tick = enable && count == CW'(SAMPLE_DIV - 1);
   assign rsp_match = rsp_channel == 5'(CHANNEL);
   always_ff @(posedge clk_clk or negedge reset_reset_n)
      if (!reset_reset_n) count <= '0;
      else count <= (!enable || tick) ? '0 : count + 1'b1;
`ifdef ADC_SEQ_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] tcnt;
   assign unused = rsp_sop ^ rsp_eop;
   assign timed_out = state == WAIT_RSP && !rsp_valid && tcnt == TW'(TIMEOUT - 1);
   always_ff @(posedge clk_clk or negedge reset_reset_n)
      if (!reset_reset_n) tcnt <= '0;
      else tcnt <= (state == WAIT_RSP && !rsp_valid) ? tcnt + 1'b1 : '0;
`else
   assign unused = rsp_sop ^ rsp_eop ^ (TIMEOUT == 0);
   assign timed_out = 1'b0;
`endif
   // Ticks are dropped (not queued) while busy; responses outside WAIT_RSP are stray.
   always_comb begin
      state_n = state;
      sample_valid_n = 1'b0;
      sample_data_n = sample_data;
      overrun_n = (overrun && !clear) || (tick && state != IDLE);
      error_n = (error && !clear) || timed_out || (rsp_valid && state != WAIT_RSP);
      unique case (state)
         IDLE: state_n = tick ? CMD : IDLE;
         CMD: state_n = cmd_ready ? WAIT_RSP : CMD;
         WAIT_RSP: begin
            if (rsp_valid) begin
               state_n = IDLE;
               sample_valid_n = rsp_match;
               sample_data_n = rsp_match ? {~rsp_data[11], rsp_data[10:0], 4'b0000} : sample_data;
               error_n = error_n || !rsp_match;
            end else if (timed_out) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
      cmd_valid_n = state_n == CMD;
   end
   always_ff @(posedge clk_clk or negedge reset_reset_n)
      if (!reset_reset_n) begin
         state <= IDLE;
         cmd_valid <= 1'b0;
         sample_valid <= 1'b0;
         sample_data <= '0;
         overrun <= 1'b0;
         error <= 1'b0;
      end else begin
         state <= state_n;
         cmd_valid <= cmd_valid_n;
         sample_valid <= sample_valid_n;
         sample_data <= sample_data_n;
         overrun <= overrun_n;
         error <= error_n;
      end
endmodule

// File: tb/tb_adc_line_in_sequencer.sv
// tb_adc_line_in_sequencer: directed bench for adc_line_in_sequencer with SAMPLE_DIV=8, CHANNEL=1.
module tb_adc_line_in_sequencer;
   logic clk_clk = 1'b0, reset_reset_n = 1'b0, enable = 1'b0, clear = 1'b0, cmd_ready = 1'b0;
   logic rsp_valid = 1'b0, rsp_sop = 1'b0, rsp_eop = 1'b0;
   logic [4:0] rsp_channel = '0;
   logic [11:0] rsp_data = '0;
   logic cmd_valid, cmd_sop, cmd_eop, sample_valid, overrun, error;
   logic [4:0] cmd_channel;
   logic [15:0] sample_data;
   int tests = 0, fails = 0;

   adc_line_in_sequencer #(.SAMPLE_DIV(8), .CHANNEL(1), .TIMEOUT(16)) dut (
      .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .enable(enable), .clear(clear),
      .cmd_valid(cmd_valid), .cmd_channel(cmd_channel), .cmd_sop(cmd_sop), .cmd_eop(cmd_eop),
      .cmd_ready(cmd_ready), .rsp_valid(rsp_valid), .rsp_channel(rsp_channel), .rsp_data(rsp_data),
      .rsp_sop(rsp_sop), .rsp_eop(rsp_eop), .sample_valid(sample_valid), .sample_data(sample_data),
      .overrun(overrun), .error(error)
   );

   always #5 clk_clk = ~clk_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_clk);
      #1;
   endtask

   task automatic wait_cmd(input int limit, output int n);
      n = 0;
      while (cmd_valid !== 1'b1 && n < limit) begin
         step();
         n++;
      end
      chk("cmd_valid_arrives", 32'(cmd_valid), 1);
   endtask

   // Entered on a visible cmd_valid cycle with cmd_ready=1; responds two cycles after the handshake.
   task automatic do_txn(input string tag, input logic [4:0] ch, input logic [11:0] d,
                         input logic exp_v, input logic [15:0] exp_d);
      step();
      chk({tag, "_cmd_drop"}, 32'(cmd_valid), 0);
      step();
      rsp_valid = 1'b1; rsp_channel = ch; rsp_data = d; rsp_sop = 1'b1; rsp_eop = 1'b1;
      step();
      rsp_valid = 1'b0; rsp_sop = 1'b0; rsp_eop = 1'b0;
      chk({tag, "_strobe"}, 32'(sample_valid), 32'(exp_v));
      chk({tag, "_data"}, 32'(sample_data), 32'(exp_d));
      step();
      chk({tag, "_one_shot"}, 32'(sample_valid), 0);
      chk({tag, "_hold"}, 32'(sample_data), 32'(exp_d));
   endtask

   initial begin
      int n;
      logic ok;
      #12;
      chk("rst_cmd_valid", 32'(cmd_valid), 0);
      chk("rst_sop_eop", 32'({cmd_sop, cmd_eop}), 0);
      chk("rst_sample_valid", 32'(sample_valid), 0);
      chk("rst_sample_data", 32'(sample_data), 0);
      chk("rst_flags", 32'({overrun, error}), 0);
      chk("rst_channel", 32'(cmd_channel), 1);
      step();
      reset_reset_n = 1'b1; enable = 1'b1; cmd_ready = 1'b1;
      // mid-scale samples, regular command period
      wait_cmd(20, n);
      chk("t1_first_cmd", n, 8);
      do_txn("t1a", 5'd1, 12'h800, 1'b1, 16'h0000);
      wait_cmd(20, n);
      chk("t1_period", n, 4);
      do_txn("t1b", 5'd1, 12'h800, 1'b1, 16'h0000);
      chk("t1_flags", 32'({overrun, error}), 0);
      // full-scale extremes
      wait_cmd(20, n);
      do_txn("t2_max", 5'd1, 12'hFFF, 1'b1, 16'h7FF0);
      wait_cmd(20, n);
      do_txn("t2_min", 5'd1, 12'h000, 1'b1, 16'h8000);
      // back-pressure: command held stable, overrun on the dropped tick, clear
      cmd_ready = 1'b0;
      wait_cmd(20, n);
      ok = 1'b1;
      repeat (20) begin
         step();
         ok &= cmd_valid === 1'b1 && cmd_sop === 1'b1 && cmd_eop === 1'b1 && cmd_channel === 5'd1;
      end
      chk("t3_cmd_stable", 32'(ok), 1);
      chk("t3_overrun_set", 32'(overrun), 1);
      enable = 1'b0; clear = 1'b1;
      step();
      clear = 1'b0;
      chk("t3_overrun_clear", 32'(overrun), 0);
      chk("t3_still_cmd", 32'(cmd_valid), 1);
      cmd_ready = 1'b1;
      do_txn("t3_inflight", 5'd1, 12'h800, 1'b1, 16'h0000);
      enable = 1'b1;
      wait_cmd(20, n);
      chk("t3_resume", n, 8);
      do_txn("t3_next", 5'd1, 12'h400, 1'b1, 16'hC000);
      chk("t3_overrun_stays", 32'(overrun), 0);
      // wrong channel
      wait_cmd(20, n);
      do_txn("t4_bad", 5'd2, 12'h555, 1'b0, 16'hC000);
      chk("t4_error", 32'(error), 1);
      chk("t4_idle", 32'(cmd_valid), 0);
      wait_cmd(20, n);
      chk("t4_period", n, 4);
      do_txn("t4_next", 5'd1, 12'hABC, 1'b1, 16'h2BC0);
      chk("t4_error_sticky", 32'(error), 1);
      clear = 1'b1;
      step();
      clear = 1'b0;
      chk("t4_error_clear", 32'(error), 0);
      // stray response in IDLE
      rsp_valid = 1'b1; rsp_channel = 5'd1; rsp_data = 12'h900;
      step();
      rsp_valid = 1'b0;
      chk("stray_idle_error", 32'(error), 1);
      chk("stray_idle_no_sample", 32'(sample_valid), 0);
      clear = 1'b1;
      step();
      clear = 1'b0;
      chk("stray_idle_clear", 32'(error), 0);
`ifdef ADC_SEQ_TIMEOUT_EN
      wait_cmd(20, n);
      n = 0;
      while (error !== 1'b1 && n < 40) begin
         step();
         n++;
      end
      chk("t5_timeout_cycles", n, 17);
      wait_cmd(20, n);
      do_txn("t5_after", 5'd1, 12'h800, 1'b1, 16'h0000);
      clear = 1'b1;
      step();
      clear = 1'b0;
      chk("t5_flags_clear", 32'({overrun, error}), 0);
`endif
      // reset during WAIT_RSP, then late response is stray
      wait_cmd(20, n);
      step();
      chk("t6_in_wait", 32'(cmd_valid), 0);
      reset_reset_n = 1'b0;
      #1;
      chk("t6_rst_cmd", 32'({cmd_valid, cmd_sop, cmd_eop}), 0);
      chk("t6_rst_sample", 32'({sample_valid, sample_data}), 0);
      chk("t6_rst_flags", 32'({overrun, error}), 0);
      chk("t6_rst_channel", 32'(cmd_channel), 1);
      step();
      step();
      reset_reset_n = 1'b1;
      step();
      rsp_valid = 1'b1; rsp_channel = 5'd1; rsp_data = 12'h800;
      step();
      rsp_valid = 1'b0;
      chk("t6_late_error", 32'(error), 1);
      chk("t6_late_no_sample", 32'(sample_valid), 0);
      chk("t6_late_data", 32'(sample_data), 0);
      step();
      chk("t6_late_no_sample2", 32'(sample_valid), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
